// File: rtl/rx_deframer.sv
// rx_deframer: receive-side frame extractor.
// Hunts the CDR bit stream for a zero preamble followed by SFD 0xA7, reads the
// PHR length byte and hands the PSDU to the host as LSB-first nibbles through a
// 2-entry valid/ready buffer.
// Optional feature macro: RX_DEFRAMER_CRC_EN (CRC-16 check over the PSDU; the
// two FCS bytes are consumed and not forwarded).
module rx_deframer #(
    parameter int MIN_ZERO_BITS = 16
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic       inBitFlag,
    input  logic       inBit,
    output logic [3:0] outData,
    output logic       outValid,
    input  logic       inReady,
    output logic       outLast,
    output logic       outBusy,
    output logic       outDone,
    output logic       outCrcOk,
    output logic       outError
);

    localparam logic [7:0] MIN_ZERO = 8'(MIN_ZERO_BITS);

`ifdef RX_DEFRAMER_CRC_EN
    typedef enum logic [1:0] {HUNT = 2'd0, LEN = 2'd1, PAYLOAD = 2'd2, FCS = 2'd3} state_t;

    // One LSB-first step of the reflected CRC-16 (poly 0x8408).
    function automatic logic [15:0] crcStep(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[0] ^ b;
        crcStep = {1'b0, crc[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
    endfunction

    logic [15:0] crc_r, nextCrc_s;
`else
    typedef enum logic [1:0] {HUNT = 2'd0, LEN = 2'd1, PAYLOAD = 2'd2} state_t;
`endif

    state_t      state_r, nextState_s;
    logic [7:0]  window_r, nextWindow_s, winShift_s;
    logic [7:0]  zeroRun_r, nextZero_s, zeroInc_s;
    logic [3:0]  bitCnt_r, nextBitCnt_s;
    logic [6:0]  shift_r, nextShift_s;
    logic [7:0]  byteShift_s;
    logic [6:0]  payLen_r, nextPayLen_s;
    logic [6:0]  byteCnt_r, nextByteCnt_s;
    logic        match_s, lenBad_s, lastByte_s, enterHunt_s;
    logic        push_s, pushLast_s;
    logic [3:0]  pushData_s;
    logic        doneNext_s, errNext_s, okNext_s;
    logic [3:0]  data1_r;
    logic        last1_r, valid1_r;
    logic        pop_s, overflow_s, headAfterPop_s, writeHead_s, writeTail_s;

    assign winShift_s  = {inBit, window_r[7:1]};
    assign zeroInc_s   = window_r[0] ? 8'd0 : ((zeroRun_r == 8'd255) ? 8'd255 : zeroRun_r + 8'd1);
    assign match_s     = (winShift_s == 8'hA7) && (zeroInc_s >= MIN_ZERO);
    assign byteShift_s = {inBit, shift_r};
`ifdef RX_DEFRAMER_CRC_EN
    assign lenBad_s    = (byteShift_s[6:0] < 7'd3);
`else
    assign lenBad_s    = (byteShift_s[6:0] == 7'd0);
`endif
    assign lastByte_s  = (byteCnt_r == payLen_r - 7'd1);
    assign outBusy     = (state_r != HUNT);

    // Buffer control: head entry is the output register, tail entry behind it.
    assign pop_s          = outValid & inReady;
    assign overflow_s     = push_s & valid1_r & ~pop_s;
    assign headAfterPop_s = pop_s ? valid1_r : outValid;
    assign writeHead_s    = push_s & ~overflow_s & ~headAfterPop_s;
    assign writeTail_s    = push_s & ~overflow_s & headAfterPop_s;
    assign enterHunt_s    = (nextState_s == HUNT) && (state_r != HUNT);

    // Next-state and datapath decisions; everything advances only on a bit strobe.
    always_comb begin
        nextState_s   = state_r;
        nextWindow_s  = window_r;
        nextZero_s    = zeroRun_r;
        nextBitCnt_s  = bitCnt_r;
        nextShift_s   = shift_r;
        nextPayLen_s  = payLen_r;
        nextByteCnt_s = byteCnt_r;
        push_s        = 1'b0;
        pushData_s    = byteShift_s[7:4];
        pushLast_s    = 1'b0;
        doneNext_s    = 1'b0;
        errNext_s     = 1'b0;
        okNext_s      = outCrcOk;
`ifdef RX_DEFRAMER_CRC_EN
        nextCrc_s     = crc_r;
`endif
        if (inBitFlag) begin
            case (state_r)
                HUNT: begin
                    nextWindow_s = winShift_s;
                    nextZero_s   = zeroInc_s;
                    if (match_s) begin
                        nextState_s  = LEN;
                        nextBitCnt_s = 4'd0;
                    end else begin
                        nextState_s  = HUNT;
                    end
                end
                LEN: begin
                    nextShift_s  = byteShift_s[7:1];
                    nextBitCnt_s = bitCnt_r + 4'd1;
                    if (bitCnt_r == 4'd7) begin
                        nextBitCnt_s = 4'd0;
                        if (lenBad_s) begin
                            errNext_s   = 1'b1;
                            nextState_s = HUNT;
                        end else begin
                            nextState_s   = PAYLOAD;
                            nextByteCnt_s = 7'd0;
`ifdef RX_DEFRAMER_CRC_EN
                            nextPayLen_s  = byteShift_s[6:0] - 7'd2;
                            nextCrc_s     = 16'h0000;
`else
                            nextPayLen_s  = byteShift_s[6:0];
`endif
                        end
                    end else begin
                        nextState_s = LEN;
                    end
                end
                PAYLOAD: begin
                    nextShift_s  = byteShift_s[7:1];
                    nextBitCnt_s = bitCnt_r + 4'd1;
`ifdef RX_DEFRAMER_CRC_EN
                    nextCrc_s    = crcStep(crc_r, inBit);
`endif
                    if (bitCnt_r[1:0] == 2'd3) begin
                        push_s     = 1'b1;
                        pushLast_s = (bitCnt_r == 4'd7) && lastByte_s;
                    end else begin
                        push_s     = 1'b0;
                    end
                    if (bitCnt_r == 4'd7) begin
                        nextBitCnt_s  = 4'd0;
                        nextByteCnt_s = byteCnt_r + 7'd1;
                        if (lastByte_s) begin
`ifdef RX_DEFRAMER_CRC_EN
                            nextState_s = FCS;
`else
                            doneNext_s  = 1'b1;
                            okNext_s    = 1'b1;
                            nextState_s = HUNT;
`endif
                        end else begin
                            nextState_s = PAYLOAD;
                        end
                    end else begin
                        nextState_s = PAYLOAD;
                    end
                end
`ifdef RX_DEFRAMER_CRC_EN
                FCS: begin
                    nextCrc_s    = crcStep(crc_r, inBit);
                    nextBitCnt_s = bitCnt_r + 4'd1;
                    if (bitCnt_r == 4'd15) begin
                        nextBitCnt_s = 4'd0;
                        doneNext_s   = 1'b1;
                        okNext_s     = (crcStep(crc_r, inBit) == 16'h0000);
                        nextState_s  = HUNT;
                    end else begin
                        nextState_s  = FCS;
                    end
                end
`endif
                default: begin
                    nextState_s = HUNT;
                end
            endcase
        end else begin
            nextState_s = state_r;
        end
    end

    // State, datapath, buffer and pulse registers; overflow aborts back to HUNT.
    always_ff @(posedge inClock) begin
        if (!inReset) begin
            state_r   <= HUNT;
            window_r  <= 8'hFF;
            zeroRun_r <= 8'd0;
            bitCnt_r  <= 4'd0;
            shift_r   <= 7'd0;
            payLen_r  <= 7'd0;
            byteCnt_r <= 7'd0;
`ifdef RX_DEFRAMER_CRC_EN
            crc_r     <= 16'h0000;
`endif
            outData   <= 4'd0;
            outLast   <= 1'b0;
            outValid  <= 1'b0;
            data1_r   <= 4'd0;
            last1_r   <= 1'b0;
            valid1_r  <= 1'b0;
            outDone   <= 1'b0;
            outCrcOk  <= 1'b0;
            outError  <= 1'b0;
        end else begin
            state_r   <= overflow_s ? HUNT : nextState_s;
            window_r  <= (overflow_s || enterHunt_s) ? 8'hFF : nextWindow_s;
            zeroRun_r <= (overflow_s || enterHunt_s) ? 8'd0 : nextZero_s;
            bitCnt_r  <= nextBitCnt_s;
            shift_r   <= nextShift_s;
            payLen_r  <= nextPayLen_s;
            byteCnt_r <= nextByteCnt_s;
`ifdef RX_DEFRAMER_CRC_EN
            crc_r     <= nextCrc_s;
`endif
            outData   <= writeHead_s ? pushData_s : (pop_s ? data1_r : outData);
            outLast   <= writeHead_s ? pushLast_s : (pop_s ? last1_r : outLast);
            outValid  <= ~overflow_s & (headAfterPop_s | writeHead_s);
            data1_r   <= writeTail_s ? pushData_s : data1_r;
            last1_r   <= writeTail_s ? pushLast_s : last1_r;
            valid1_r  <= ~overflow_s & (writeTail_s | (valid1_r & ~pop_s));
            outDone   <= doneNext_s & ~overflow_s;
            outCrcOk  <= overflow_s ? outCrcOk : okNext_s;
            outError  <= errNext_s | overflow_s;
        end
    end

endmodule

// File: tb/tb_rx_deframer.sv
// tb_rx_deframer: directed, table-driven bench for rx_deframer.
// Frames are serialised LSB-first one bit per cycle; a negedge monitor records
// accepted nibbles and pulses. Build-dependent vectors follow RX_DEFRAMER_CRC_EN.
module tb_rx_deframer;

    logic       inClock = 1'b0;
    logic       inReset, inBitFlag, inBit, inReady;
    logic [3:0] outData;
    logic       outValid, outLast, outBusy, outDone, outCrcOk, outError;

    rx_deframer #(.MIN_ZERO_BITS(16)) dut (
        .inClock(inClock), .inReset(inReset), .inBitFlag(inBitFlag), .inBit(inBit),
        .outData(outData), .outValid(outValid), .inReady(inReady), .outLast(outLast),
        .outBusy(outBusy), .outDone(outDone), .outCrcOk(outCrcOk), .outError(outError)
    );

    always #5 inClock = ~inClock;

    typedef struct {
        int          zeros;
        logic [7:0]  phr;
        int          nBytes;
        logic [47:0] bytes;    // byte i at [8*i +: 8]
        int          addFcs;
        logic [15:0] fcsXor;
        int          expNib;
        logic [31:0] nib;      // expected nibble k at [4*k +: 4]
        int          expDone;
        int          expErr;
        logic        expOk;
        int          expBusy;
    } vec_t;

    localparam int NV = 5;
`ifdef RX_DEFRAMER_CRC_EN
    localparam logic [7:0] PHR4 = 8'h06;
`else
    localparam logic [7:0] PHR4 = 8'h04;
`endif

    vec_t vecs [NV];
    int   checks = 0;
    int   errors = 0;

    logic [4:0] nibQ [$];
    int         doneCnt = 0;
    int         errCnt  = 0;
    int         busyCnt = 0;
    logic       lastOk  = 1'b0;

    // Record accepted nibbles and output pulses away from the active edge.
    always @(negedge inClock) begin
        if (inReset) begin
            if (outValid && inReady) nibQ.push_back({outLast, outData});
            if (outDone) begin
                doneCnt <= doneCnt + 1;
                lastOk  <= outCrcOk;
            end
            if (outError) errCnt  <= errCnt + 1;
            if (outBusy)  busyCnt <= busyCnt + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sendBit(input logic b);
        inBitFlag = 1'b1;
        inBit     = b;
        @(posedge inClock);
        #1;
        inBitFlag = 1'b0;
        inBit     = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) sendBit(v[i]);
    endtask

    task automatic sendZeros(input int n);
        for (int i = 0; i < n; i++) sendBit(1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge inClock);
        #1;
    endtask

    // Reference CRC-16 (reflected 0x8408, init 0) over n bytes, LSB-first.
    function automatic logic [15:0] fcsOf(input logic [47:0] bytes, input int n);
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ bytes[8*i + j];
                c  = {1'b0, c[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
            end
        end
        return c;
    endfunction

    task automatic applyVec(input vec_t v, input int idx);
        int          nb, db, eb, bb;
        logic [15:0] fcs;
        logic [4:0]  want;
        nb = nibQ.size(); db = doneCnt; eb = errCnt; bb = busyCnt;
        sendZeros(v.zeros);
        sendByte(8'hA7);
        sendByte(v.phr);
        for (int i = 0; i < v.nBytes; i++) sendByte(v.bytes[8*i +: 8]);
        if (v.addFcs != 0) begin
            fcs = fcsOf(v.bytes, v.nBytes) ^ v.fcsXor;
            sendByte(fcs[7:0]);
            sendByte(fcs[15:8]);
        end
        idle(8);
        check($sformatf("v%0d nibCount", idx), nibQ.size() - nb, v.expNib);
        for (int k = 0; k < v.expNib; k++) begin
            if (nb + k < nibQ.size()) begin
                want = {(k == v.expNib - 1) ? 1'b1 : 1'b0, v.nib[4*k +: 4]};
                check($sformatf("v%0d nib%0d {last,data}", idx, k), int'(nibQ[nb + k]), int'(want));
            end
        end
        check($sformatf("v%0d doneCount", idx), doneCnt - db, v.expDone);
        check($sformatf("v%0d errorCount", idx), errCnt - eb, v.expErr);
        if (v.expDone != 0) check($sformatf("v%0d crcOk", idx), int'(lastOk), int'(v.expOk));
        check($sformatf("v%0d busySeen", idx), (busyCnt - bb > 0) ? 1 : 0, v.expBusy);
    endtask

    initial begin
`ifdef RX_DEFRAMER_CRC_EN
        vecs[0] = '{32, 8'h06, 4, 48'h0000_34333231, 1, 16'h0000, 8, 32'h34333231, 1, 0, 1'b1, 1};
        vecs[1] = '{32, 8'h06, 4, 48'h0000_34333231, 1, 16'h0100, 8, 32'h34333231, 1, 0, 1'b0, 1};
        vecs[2] = '{20, 8'h02, 0, 48'h0,             0, 16'h0000, 0, 32'h0,        0, 1, 1'b0, 1};
        vecs[3] = '{8,  8'h06, 4, 48'h0000_34333231, 1, 16'h0000, 0, 32'h0,        0, 0, 1'b0, 0};
        vecs[4] = '{16, 8'h03, 1, 48'h0000_000000A5, 1, 16'h0000, 2, 32'h000000A5, 1, 0, 1'b1, 1};
`else
        vecs[0] = '{32, 8'h04, 4, 48'h0000_E1965A3C, 0, 16'h0000, 8, 32'hE1965A3C, 1, 0, 1'b1, 1};
        vecs[1] = '{8,  8'h02, 2, 48'h0000_000055AA, 0, 16'h0000, 0, 32'h0,        0, 0, 1'b0, 0};
        vecs[2] = '{16, 8'h02, 2, 48'h0000_0000EF12, 0, 16'h0000, 4, 32'h0000EF12, 1, 0, 1'b1, 1};
        vecs[3] = '{20, 8'h80, 0, 48'h0,             0, 16'h0000, 0, 32'h0,        0, 1, 1'b0, 1};
        vecs[4] = '{24, 8'h81, 1, 48'h0000_0000007B, 0, 16'h0000, 2, 32'h0000007B, 1, 0, 1'b1, 1};
`endif
        inReset = 1'b0; inBitFlag = 1'b0; inBit = 1'b0; inReady = 1'b1;
        repeat (3) @(posedge inClock);
        @(negedge inClock);
        check("rst outData",  int'(outData),  0);
        check("rst outValid", int'(outValid), 0);
        check("rst outLast",  int'(outLast),  0);
        check("rst outBusy",  int'(outBusy),  0);
        check("rst outDone",  int'(outDone),  0);
        check("rst outCrcOk", int'(outCrcOk), 0);
        check("rst outError", int'(outError), 0);
        @(posedge inClock); #1;
        inReset = 1'b1;

        for (int v = 0; v < NV; v++) applyVec(vecs[v], v);

        // Overflow: host stalled, third nibble push with a full buffer aborts.
        begin
            int db, eb, nb;
            inReady = 1'b0;
            db = doneCnt; eb = errCnt; nb = nibQ.size();
            sendZeros(32); sendByte(8'hA7); sendByte(PHR4);
            sendByte(8'h3C);
            for (int i = 0; i < 3; i++) sendBit(1'b0);
            check("ovf no error before 3rd push", int'(outError), 0);
            check("ovf buffer full valid", int'(outValid), 1);
            sendBit(1'b1);
            check("ovf outError pulse", int'(outError), 1);
            check("ovf buffer flushed", int'(outValid), 0);
            check("ovf outBusy low", int'(outBusy), 0);
            idle(4);
            check("ovf pulse one cycle", int'(outError), 0);
            check("ovf errorCount", errCnt - eb, 1);
            check("ovf no done", doneCnt - db, 0);
            check("ovf no nibbles", nibQ.size() - nb, 0);
            inReady = 1'b1;
        end

        // Bad length: outError right after the 8th PHR bit, then a good frame.
        begin
            sendZeros(32); sendByte(8'hA7);
            for (int i = 0; i < 7; i++) sendBit(1'b0);
            check("badlen no early error", int'(outError), 0);
            sendBit(1'b1);
            check("badlen outError pulse", int'(outError), 1);
            check("badlen outBusy low", int'(outBusy), 0);
            idle(2);
            applyVec(vecs[0], 10);
        end

        // Reset mid-payload with two nibbles buffered, then a fresh frame.
        begin
            int db, eb;
            inReady = 1'b0;
            db = doneCnt; eb = errCnt;
            sendZeros(32); sendByte(8'hA7); sendByte(PHR4); sendByte(8'h3C);
            idle(1);
            check("midrst valid before", int'(outValid), 1);
            check("midrst busy before", int'(outBusy), 1);
            inReset = 1'b0;
            @(posedge inClock); #1;
            check("midrst outData",  int'(outData),  0);
            check("midrst outValid", int'(outValid), 0);
            check("midrst outLast",  int'(outLast),  0);
            check("midrst outBusy",  int'(outBusy),  0);
            check("midrst outDone",  int'(outDone),  0);
            check("midrst outCrcOk", int'(outCrcOk), 0);
            check("midrst outError", int'(outError), 0);
            inReset = 1'b1;
            inReady = 1'b1;
            idle(2);
            check("midrst no done", doneCnt - db, 0);
            check("midrst no error", errCnt - eb, 0);
            applyVec(vecs[0], 11);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
